// File: rtl/swervolf_timer_bank_if.sv
// AXI4 slave-side signal bundle for swervolf_timer_bank.
// Latency: none, this is wiring only.
// Backpressure: carries the AXI valid/ready pairs unchanged.
// Ports: AW/W/B/AR/R channel signals. i_* are driven by the master and
// o_* by the slave; the names match the block's bus pin names.
interface swervolf_timer_bank_if #(
  parameter int ID_WIDTH = 6
);
  logic [ID_WIDTH-1:0] i_awid;
  logic [11:0]         i_awaddr;
  logic [7:0]          i_awlen;
  logic                i_awvalid;
  logic                o_awready;

  logic [63:0]         i_wdata;
  logic [7:0]          i_wstrb;
  logic                i_wlast;
  logic                i_wvalid;
  logic                o_wready;

  logic [ID_WIDTH-1:0] o_bid;
  logic [1:0]          o_bresp;
  logic                o_bvalid;
  logic                i_bready;

  logic [ID_WIDTH-1:0] i_arid;
  logic [11:0]         i_araddr;
  logic [7:0]          i_arlen;
  logic                i_arvalid;
  logic                o_arready;

  logic [ID_WIDTH-1:0] o_rid;
  logic [63:0]         o_rdata;
  logic [1:0]          o_rresp;
  logic                o_rlast;
  logic                o_rvalid;
  logic                i_rready;

  modport master (
    output i_awid, i_awaddr, i_awlen, i_awvalid, input o_awready,
    output i_wdata, i_wstrb, i_wlast, i_wvalid, input o_wready,
    input  o_bid, o_bresp, o_bvalid, output i_bready,
    output i_arid, i_araddr, i_arlen, i_arvalid, input o_arready,
    input  o_rid, o_rdata, o_rresp, o_rlast, o_rvalid, output i_rready
  );

  modport slave (
    input  i_awid, i_awaddr, i_awlen, i_awvalid, output o_awready,
    input  i_wdata, i_wstrb, i_wlast, i_wvalid, output o_wready,
    output o_bid, o_bresp, o_bvalid, input i_bready,
    input  i_arid, i_araddr, i_arlen, i_arvalid, output o_arready,
    output o_rid, o_rdata, o_rresp, o_rlast, o_rvalid, input i_rready
  );
endinterface

// File: rtl/swervolf_timer_bank.sv
// Machine timer with prescaler, N compare channels, GPIO register, AXI4 slave.
// Latency: writes take effect at the AW/W handshake edge; read data 1 cycle after AR.
// Backpressure: AW/W accepted together only in write idle; B and R hold until ready.
// Ports: clk/rst (sync, active high), axi (slave modport of the bus bundle),
// o_gpio (GPIO_OUT register), o_timer_irq (registered per-channel interrupts).
module swervolf_timer_bank #(
  parameter int ID_WIDTH   = 6,
  parameter int N_TIMERS   = 2,
  parameter int GPIO_W     = 8,
  parameter int PRESCALE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  swervolf_timer_bank_if.slave axi,
  output logic [GPIO_W-1:0]    o_gpio,
  output logic [N_TIMERS-1:0]  o_timer_irq
);

  localparam logic [1:0] W_IDLE  = 2'd0;
  localparam logic [1:0] W_DRAIN = 2'd1;
  localparam logic [1:0] W_RESP  = 2'd2;
  localparam logic [0:0] R_IDLE  = 1'b0;
  localparam logic [0:0] R_DATA  = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Word index 0..4 are the control registers, 32+i are the compare registers.
  function automatic logic mapped(input logic [8:0] idx);
    return (idx <= 9'd4) || ((idx >= 9'd32) && (idx < 9'(32 + N_TIMERS)));
  endfunction

  logic [63:0]           mtime_q, mtime_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d, prescale_q, prescale_d;
  logic [GPIO_W-1:0]     gpio_q, gpio_d;
  logic [N_TIMERS-1:0]   irq_en_q, irq_en_d, irq_status, irq_q;
  logic [63:0]           cmp_q [N_TIMERS];
  logic [63:0]           cmp_d [N_TIMERS];

  logic [1:0]          w_state_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [1:0]          bresp_q;
  logic                aw_hs, wr_fire, tick;
  logic [8:0]          wr_idx, rd_idx;
  logic [63:0]         wmask, rd_val;

  logic [0:0]          r_state_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [63:0]         rdata_q;
  logic [1:0]          rresp_q;
  logic                rlast_q, ar_hs;
  logic [7:0]          rlen_q, rbeat_q;

  // The byte offset inside a 64-bit word does not select anything.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{axi.i_awaddr[2:0], axi.i_araddr[2:0]};

  // Ready is combinational on valid so the AW/W acceptance is a single-cycle
  // pulse; gating with rst keeps the handshakes dead while in reset.
  assign aw_hs   = (w_state_q == W_IDLE) & axi.i_awvalid & axi.i_wvalid & ~rst;
  assign ar_hs   = (r_state_q == R_IDLE) & axi.i_arvalid & ~rst;
  assign wr_fire = aw_hs & (axi.i_awlen == 8'd0);
  assign wr_idx  = axi.i_awaddr[11:3];
  assign rd_idx  = axi.i_araddr[11:3];
  assign tick    = (pcnt_q == prescale_q);

  always_comb begin
    for (int b = 0; b < 8; b++) wmask[8*b +: 8] = {8{axi.i_wstrb[b]}};
  end

  always_comb begin
    for (int i = 0; i < N_TIMERS; i++) irq_status[i] = (mtime_q >= cmp_q[i]);
  end

  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    pcnt_d     = tick ? '0 : pcnt_q + PRESCALE_W'(1);
    prescale_d = prescale_q;
    gpio_d     = gpio_q;
    irq_en_d   = irq_en_q;
    for (int i = 0; i < N_TIMERS; i++) cmp_d[i] = cmp_q[i];
    if (wr_fire) begin
      case (wr_idx)
        // A bus write to MTIME overrides the increment of the same cycle.
        9'd0: mtime_d = (mtime_q & ~wmask) | (axi.i_wdata & wmask);
        9'd1: begin
          prescale_d = (prescale_q & ~wmask[PRESCALE_W-1:0]) |
                       (axi.i_wdata[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0]);
          pcnt_d     = '0;
        end
        9'd2: gpio_d = (gpio_q & ~wmask[GPIO_W-1:0]) |
                       (axi.i_wdata[GPIO_W-1:0] & wmask[GPIO_W-1:0]);
        9'd4: irq_en_d = (irq_en_q & ~wmask[N_TIMERS-1:0]) |
                         (axi.i_wdata[N_TIMERS-1:0] & wmask[N_TIMERS-1:0]);
        default: begin
          for (int i = 0; i < N_TIMERS; i++) begin
            if (wr_idx == 9'(32 + i)) cmp_d[i] = (cmp_q[i] & ~wmask) | (axi.i_wdata & wmask);
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      9'd0: rd_val = mtime_q;
      9'd1: rd_val = 64'(prescale_q);
      9'd2: rd_val = 64'(gpio_q);
      9'd3: rd_val = 64'(irq_status);
      9'd4: rd_val = 64'(irq_en_q);
      default: begin
        for (int i = 0; i < N_TIMERS; i++) begin
          if (rd_idx == 9'(32 + i)) rd_val = cmp_q[i];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      pcnt_q     <= '0;
      prescale_q <= '0;
      gpio_q     <= '0;
      irq_en_q   <= '0;
      irq_q      <= '0;
      for (int i = 0; i < N_TIMERS; i++) cmp_q[i] <= '1;
    end else begin
      mtime_q    <= mtime_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      gpio_q     <= gpio_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_en_q & irq_status;
      for (int i = 0; i < N_TIMERS; i++) cmp_q[i] <= cmp_d[i];
    end
  end

  // Bursts are not supported: the first beat is taken without writing and the
  // remaining beats are swallowed before a single SLVERR response.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (w_state_q)
        W_IDLE: if (aw_hs) begin
          bid_q <= axi.i_awid;
          if (axi.i_awlen == 8'd0) begin
            bresp_q   <= mapped(wr_idx) ? RESP_OKAY : RESP_DECERR;
            w_state_q <= W_RESP;
          end else begin
            bresp_q   <= RESP_SLVERR;
            w_state_q <= axi.i_wlast ? W_RESP : W_DRAIN;
          end
        end
        W_DRAIN: if (axi.i_wvalid && axi.i_wlast) w_state_q <= W_RESP;
        W_RESP:  if (axi.i_bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (ar_hs) begin
          rid_q     <= axi.i_arid;
          rlen_q    <= axi.i_arlen;
          rbeat_q   <= '0;
          r_state_q <= R_DATA;
          if (axi.i_arlen == 8'd0) begin
            rdata_q <= rd_val;
            rresp_q <= mapped(rd_idx) ? RESP_OKAY : RESP_DECERR;
            rlast_q <= 1'b1;
          end else begin
            rdata_q <= '0;
            rresp_q <= RESP_SLVERR;
            rlast_q <= 1'b0;
          end
        end
        default: if (axi.i_rready) begin
          if (rlast_q) begin
            rlast_q   <= 1'b0;
            r_state_q <= R_IDLE;
          end else begin
            rbeat_q <= rbeat_q + 8'd1;
            rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
          end
        end
      endcase
    end
  end

  assign axi.o_awready = aw_hs;
  assign axi.o_wready  = aw_hs | ((w_state_q == W_DRAIN) & ~rst);
  assign axi.o_bvalid  = (w_state_q == W_RESP);
  assign axi.o_bid     = bid_q;
  assign axi.o_bresp   = bresp_q;
  assign axi.o_arready = ar_hs;
  assign axi.o_rvalid  = (r_state_q == R_DATA);
  assign axi.o_rid     = rid_q;
  assign axi.o_rdata   = rdata_q;
  assign axi.o_rresp   = rresp_q;
  assign axi.o_rlast   = rlast_q;
  assign o_gpio        = gpio_q;
  assign o_timer_irq   = irq_q;

endmodule

// File: tb/tb_swervolf_timer_bank.sv
// Self-checking bench for swervolf_timer_bank: scoreboard of B and R responses.
// Latency: expected responses are queued at stimulus time and popped on handshake.
// Backpressure: the read path is exercised with a toggling ready.
module tb_swervolf_timer_bank;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] gpio;
  logic [1:0] irq;

  always #5 clk = ~clk;

  swervolf_timer_bank_if #(.ID_WIDTH(6)) bus();

  swervolf_timer_bank #(
    .ID_WIDTH(6), .N_TIMERS(2), .GPIO_W(8), .PRESCALE_W(16)
  ) dut (
    .clk(clk), .rst(rst), .axi(bus), .o_gpio(gpio), .o_timer_irq(irq)
  );

  typedef struct packed {
    logic [5:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } rexp_t;

  bexp_t bq[$];
  rexp_t rq[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int hs_cyc = 0;
  int mt_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [7:0] len,
                           input logic [5:0] id, input logic [1:0] exp_resp);
    int n;
    bexp_t e;
    e.id = id;
    e.resp = exp_resp;
    bq.push_back(e);
    bus.i_awid = id; bus.i_awaddr = addr; bus.i_awlen = len; bus.i_awvalid = 1'b1;
    bus.i_wdata = data; bus.i_wstrb = strb; bus.i_wlast = (len == 8'd0); bus.i_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_ready", bus.o_awready, 1);
    chk("w_ready_with_aw", bus.o_wready, 1);
    if (!bus.o_awready) begin
      bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bq.delete();
      return;
    end
    @(posedge clk); #1;
    hs_cyc = cyc;
    bus.i_awvalid = 1'b0;
    for (int b = 1; b <= int'(len); b++) begin
      bus.i_wlast = (b == int'(len));
      n = 0;
      @(negedge clk);
      while (!bus.o_wready && n < 50) begin @(negedge clk); n++; end
      chk("w_drain_ready", bus.o_wready, 1);
      @(posedge clk); #1;
    end
    bus.i_wvalid = 1'b0; bus.i_wlast = 1'b0;
    bus.i_bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_bvalid && n < 50) begin @(negedge clk); n++; end
    if (bus.o_bvalid) begin
      e = bq.pop_front();
      chk("bid", bus.o_bid, e.id);
      chk("bresp", bus.o_bresp, e.resp);
    end else begin
      chk("b_timeout", 0, 1);
      bq.delete();
    end
    @(posedge clk); #1;
    bus.i_bready = 1'b0;
  endtask

  // mt=1: the expected MTIME value is derived at the AR handshake from the
  // number of cycles since MTIME was last loaded with mt_base.
  task automatic axi_read(input logic [11:0] addr, input logic [7:0] len, input logic [5:0] id,
                          input logic [63:0] exp_d, input logic [1:0] exp_r, input bit tog,
                          input bit mt, input logic [63:0] mt_base, input int mt_p);
    int n, d;
    rexp_t e, s;
    bit have_snap;
    if (!mt) begin
      for (int b = 0; b <= int'(len); b++) begin
        e.lo = exp_d; e.hi = exp_d; e.resp = exp_r; e.id = id;
        e.last = (b == int'(len));
        rq.push_back(e);
      end
    end
    bus.i_arid = id; bus.i_araddr = addr; bus.i_arlen = len; bus.i_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_ready", bus.o_arready, 1);
    if (!bus.o_arready) begin
      bus.i_arvalid = 1'b0; rq.delete();
      return;
    end
    @(posedge clk); #1;
    bus.i_arvalid = 1'b0;
    if (mt) begin
      d = cyc - mt_cyc;
      e.lo = mt_base + 64'((d - 1) / (mt_p + 1));
      e.hi = mt_base + 64'((d - 1 + mt_p) / (mt_p + 1));
      e.resp = 2'b00; e.last = 1'b1; e.id = id;
      rq.push_back(e);
    end
    bus.i_rready = tog ? 1'b0 : 1'b1;
    have_snap = 1'b0;
    s = '0;
    n = 0;
    while (rq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.o_rvalid) begin
        if (have_snap) begin
          chk("r_hold_data", bus.o_rdata, s.lo);
          chk("r_hold_resp", bus.o_rresp, s.resp);
          chk("r_hold_last", bus.o_rlast, s.last);
        end
        if (bus.i_rready) begin
          e = rq.pop_front();
          chk("rid", bus.o_rid, e.id);
          if (e.lo == e.hi) chk("rdata", bus.o_rdata, e.lo);
          else chk("rdata_in_window", (bus.o_rdata - e.lo) <= (e.hi - e.lo), 1);
          chk("rresp", bus.o_rresp, e.resp);
          chk("rlast", bus.o_rlast, e.last);
          have_snap = 1'b0;
        end else begin
          s.lo = bus.o_rdata; s.resp = bus.o_rresp; s.last = bus.o_rlast;
          have_snap = 1'b1;
        end
      end
      @(posedge clk); #1;
      if (tog) bus.i_rready = ~bus.i_rready;
    end
    if (rq.size() > 0) begin
      chk("r_timeout", 0, 1);
      rq.delete();
    end
    bus.i_rready = 1'b0;
    chk("r_back_idle", bus.o_rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus.i_awid = '0; bus.i_awaddr = '0; bus.i_awlen = '0; bus.i_awvalid = 1'b0;
    bus.i_wdata = '0; bus.i_wstrb = '0; bus.i_wlast = 1'b0; bus.i_wvalid = 1'b0;
    bus.i_bready = 1'b0;
    bus.i_arid = '0; bus.i_araddr = '0; bus.i_arlen = '0; bus.i_arvalid = 1'b0;
    bus.i_rready = 1'b0;

    // Reset state, with requests pending so the readies are really tested.
    repeat (3) @(posedge clk);
    #1;
    bus.i_awvalid = 1'b1; bus.i_wvalid = 1'b1; bus.i_arvalid = 1'b1;
    @(negedge clk);
    chk("rst_awready", bus.o_awready, 0);
    chk("rst_wready", bus.o_wready, 0);
    chk("rst_arready", bus.o_arready, 0);
    chk("rst_bvalid", bus.o_bvalid, 0);
    chk("rst_rvalid", bus.o_rvalid, 0);
    chk("rst_rlast", bus.o_rlast, 0);
    chk("rst_bresp", bus.o_bresp, 0);
    chk("rst_rresp", bus.o_rresp, 0);
    chk("rst_bid", bus.o_bid, 0);
    chk("rst_rid", bus.o_rid, 0);
    chk("rst_rdata", bus.o_rdata, 0);
    chk("rst_gpio", gpio, 0);
    chk("rst_irq", irq, 0);
    bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0; bus.i_arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    mt_cyc = cyc;

    // GPIO write, ID echo, read-back.
    axi_write(12'h010, 64'hA5, 8'h01, 8'd0, 6'h2A, 2'b00);
    chk("gpio_a5", gpio, 8'hA5);
    axi_read(12'h010, 8'd0, 6'h15, 64'hA5, 2'b00, 1'b0, 1'b0, '0, 0);

    // Prescaler of 3: MTIME advances every 4 cycles.
    axi_write(12'h008, 64'd3, 8'hFF, 8'd0, 6'h01, 2'b00);
    axi_write(12'h000, 64'd0, 8'hFF, 8'd0, 6'h02, 2'b00);
    mt_cyc = hs_cyc;
    repeat (40) @(posedge clk);
    #1;
    axi_read(12'h000, 8'd0, 6'h03, '0, 2'b00, 1'b0, 1'b1, 64'd0, 3);
    axi_read(12'h008, 8'd0, 6'h04, 64'd3, 2'b00, 1'b0, 1'b0, '0, 0);

    // Compare channel 0 at 20 with prescale 0.
    axi_write(12'h000, 64'd0, 8'hFF, 8'd0, 6'h05, 2'b00);
    axi_write(12'h100, 64'd20, 8'hFF, 8'd0, 6'h06, 2'b00);
    axi_write(12'h020, 64'd1, 8'hFF, 8'd0, 6'h07, 2'b00);
    axi_write(12'h008, 64'd0, 8'hFF, 8'd0, 6'h08, 2'b00);
    axi_write(12'h000, 64'd0, 8'hFF, 8'd0, 6'h09, 2'b00);
    mt_cyc = hs_cyc;
    chk("irq_before_match", irq, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!irq[0] && n < 100);
    chk("irq_rise_cycle", cyc - mt_cyc, 21);
    chk("irq_rise_value", irq, 2'b01);
    @(posedge clk); #1;
    axi_read(12'h018, 8'd0, 6'h0A, 64'h1, 2'b00, 1'b0, 1'b0, '0, 0);
    axi_write(12'h100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 6'h0B, 2'b00);
    chk("irq_cleared", irq, 0);

    // IRQ_STATUS is read-only; writes are acknowledged and ignored.
    axi_write(12'h018, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 6'h0C, 2'b00);
    axi_read(12'h018, 8'd0, 6'h0D, 64'h0, 2'b00, 1'b0, 1'b0, '0, 0);

    // Byte strobes on MTIMECMP[1].
    axi_write(12'h108, 64'h1122_3344_5566_7788, 8'hFF, 8'd0, 6'h0E, 2'b00);
    axi_write(12'h108, 64'hAABB_CCDD_EEFF_0011, 8'h0F, 8'd0, 6'h0F, 2'b00);
    axi_read(12'h108, 8'd0, 6'h10, 64'h1122_3344_EEFF_0011, 2'b00, 1'b0, 1'b0, '0, 0);

    // Unmapped addresses.
    axi_write(12'h030, 64'h55, 8'hFF, 8'd0, 6'h11, 2'b11);
    axi_read(12'h110, 8'd0, 6'h12, 64'h0, 2'b11, 1'b0, 1'b0, '0, 0);

    // Reset while the write response is pending.
    bus.i_awid = 6'h13; bus.i_awaddr = 12'h010; bus.i_awlen = 8'd0; bus.i_awvalid = 1'b1;
    bus.i_wdata = 64'h5A; bus.i_wstrb = 8'hFF; bus.i_wlast = 1'b1; bus.i_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_awready && n < 50) begin @(negedge clk); n++; end
    chk("rstw_aw_ready", bus.o_awready, 1);
    @(posedge clk); #1;
    bus.i_awvalid = 1'b0; bus.i_wvalid = 1'b0;
    @(negedge clk);
    chk("rstw_bvalid_pending", bus.o_bvalid, 1);
    chk("rstw_gpio_written", gpio, 8'h5A);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_bvalid_dropped", bus.o_bvalid, 0);
    chk("rstw_gpio_reset", gpio, 0);
    chk("rstw_irq_reset", irq, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mt_cyc = cyc;
    axi_read(12'h000, 8'd0, 6'h14, '0, 2'b00, 1'b0, 1'b1, 64'd0, 0);
    axi_read(12'h008, 8'd0, 6'h16, 64'h0, 2'b00, 1'b0, 1'b0, '0, 0);
    axi_read(12'h020, 8'd0, 6'h17, 64'h0, 2'b00, 1'b0, 1'b0, '0, 0);
    axi_read(12'h100, 8'd0, 6'h18, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b0, '0, 0);
    axi_read(12'h108, 8'd0, 6'h19, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 1'b0, '0, 0);

    // MTIME wrap with default compare values.
    axi_write(12'h000, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 8'd0, 6'h1A, 2'b00);
    mt_cyc = hs_cyc;
    axi_read(12'h000, 8'd0, 6'h1B, '0, 2'b00, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("irq_quiet_on_wrap", irq, 0);
    end
    @(posedge clk); #1;

    // Bursts: read len 3 under backpressure, write len 1 discarded.
    axi_read(12'h000, 8'd3, 6'h1C, 64'h0, 2'b10, 1'b1, 1'b0, '0, 0);
    axi_write(12'h010, 64'hFF, 8'hFF, 8'd1, 6'h1D, 2'b10);
    chk("gpio_after_burst", gpio, 0);
    axi_read(12'h010, 8'd0, 6'h1E, 64'h0, 2'b00, 1'b0, 1'b0, '0, 0);

    // Out-of-range read.
    axi_read(12'h800, 8'd0, 6'h1F, 64'h0, 2'b11, 1'b0, 1'b0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/swervolf_timer_bank.md
SWERVOLF_TIMER_BANK -- requirements
Module: swervolf_timer_bank

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 6, AXI ID width.
REQ-002 SHALL have parameter N_TIMERS, default 2, number of compare channels, legal range 1..8.
REQ-003 SHALL have parameter GPIO_W, default 8, GPIO output width, legal range 1..32.
REQ-004 SHALL have parameter PRESCALE_W, default 16, prescaler width, legal range 1..32.
REQ-005 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-007 SHALL have AW ports: i_awid (ID_WIDTH), i_awaddr (12), i_awlen (8), i_awvalid (1) as inputs, and o_awready (1) as output.
REQ-008 SHALL have W ports: i_wdata (64), i_wstrb (8), i_wlast (1), i_wvalid (1) as inputs, and o_wready (1) as output.
REQ-009 SHALL have B ports: o_bid (ID_WIDTH), o_bresp (2), o_bvalid (1) as outputs, and i_bready (1) as input.
REQ-010 SHALL have AR ports: i_arid (ID_WIDTH), i_araddr (12), i_arlen (8), i_arvalid (1) as inputs, and o_arready (1) as output.
REQ-011 SHALL have R ports: o_rid (ID_WIDTH), o_rdata (64), o_rresp (2), o_rlast (1), o_rvalid (1) as outputs, and i_rready (1) as input.
REQ-012 SHALL have port o_gpio, output, GPIO_W bits; the GPIO_OUT register.
REQ-013 SHALL have port o_timer_irq, output, N_TIMERS bits; one registered interrupt per channel.

Function
REQ-014 Register map SHALL be decoded on addr[11:3], 64-bit words:
- 0x000 MTIME, RW.
- 0x008 PRESCALE, RW, low PRESCALE_W bits.
- 0x010 GPIO_OUT, RW, low GPIO_W bits.
- 0x018 IRQ_STATUS, RO.
- 0x020 IRQ_EN, RW, low N_TIMERS bits.
- 0x100+8*i MTIMECMP[i], RW, for i < N_TIMERS.
REQ-015 Unmapped addresses SHALL return DECERR (2'b11); reads return data 0 and writes are discarded. Unused register bits SHALL read 0.
REQ-016 Writes SHALL honour i_wstrb per byte; IRQ_STATUS writes SHALL be ignored with OKAY.
REQ-017 Prescaler counter SHALL count 0..PRESCALE; MTIME increments by 1 in the cycle the counter equals PRESCALE, then the counter returns to 0.
- PRESCALE=0 means MTIME increments every cycle.
REQ-018 MTIME SHALL wrap from 2^64-1 to 0 with no flag.
REQ-019 A bus write to MTIME in an increment cycle SHALL win; the increment is lost.
REQ-020 A write to PRESCALE SHALL clear the prescaler counter.
REQ-021 IRQ_STATUS[i] SHALL equal (MTIME >= MTIMECMP[i]), a 64-bit unsigned compare, independent of IRQ_EN.
REQ-022 o_timer_irq[i] SHALL be a register: IRQ_EN[i] & IRQ_STATUS[i], sampled one cycle after the condition.
- It is level type and clears one cycle after MTIMECMP[i] is written above MTIME.
REQ-023 Write FSM states: W_IDLE, W_DRAIN, W_RESP.
REQ-024 In W_IDLE, when i_awvalid and i_wvalid are both high, o_awready and o_wready SHALL pulse together for one cycle, and the FSM captures id, addr and len.
- len=0: perform the write and go to W_RESP.
- len!=0: perform no write and go to W_DRAIN (if that beat had no wlast).
REQ-025 W_DRAIN SHALL hold o_wready=1 and consume beats until i_wlast, then go to W_RESP with SLVERR (2'b10).
REQ-026 W_RESP SHALL hold o_bvalid with o_bid=captured id until i_bready, then return to W_IDLE; o_awready and o_wready stay 0 meanwhile.
REQ-027 Read FSM states: R_IDLE, R_DATA.
REQ-028 In R_IDLE, when i_arvalid is high, o_arready SHALL pulse for one cycle and the FSM captures id, addr and len.
- o_rvalid rises the next cycle: read latency is 1 cycle after the AR handshake.
REQ-029 For len=0, a single beat SHALL be returned with o_rlast=1.
REQ-030 For len!=0, len+1 beats SHALL be returned, each with data 0 and SLVERR, and o_rlast only on the final beat.
- A beat advances on o_rvalid & i_rready.
REQ-031 R_DATA SHALL hold o_rdata, o_rresp and o_rlast stable while o_rvalid=1 and i_rready=0.
REQ-032 Read and write FSMs SHALL run concurrently.
- A read of a register written in the same cycle returns the old value.
- A read of MTIME returns the value at the AR handshake cycle.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL set:
- MTIME=0, prescaler counter=0, PRESCALE=0, GPIO_OUT=0, IRQ_EN=0;
- MTIMECMP[*] = all ones;
- o_timer_irq=0, o_gpio=0;
- o_awready, o_wready, o_bvalid, o_arready, o_rvalid, o_rlast all 0;
- o_bresp, o_rresp, o_bid, o_rid, o_rdata all 0;
- both FSMs in their IDLE state.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no response issued and no register updated.

Verification
REQ-035 Write 0xA5 to GPIO_OUT (0x010), wstrb=0x01, len=0 -> o_gpio=0xA5, bresp=OKAY, bid echoes awid.
REQ-036 PRESCALE=3, MTIME=0 -> MTIME increments once every 4 cycles; read of 0x000 after 40 cycles returns 10 (+/-1 for the read cycle).
REQ-037 IRQ_EN=0x1, MTIMECMP[0]=20, PRESCALE=0, MTIME=0 -> o_timer_irq[0] rises once MTIME reaches 20 (one cycle later); a write of MTIMECMP[0]=all ones clears it.
REQ-038 MTIME=0xFFFF_FFFF_FFFF_FFFE, PRESCALE=0 -> MTIME reads 0 two cycles later; o_timer_irq stays 0 with default compare values.
REQ-039 Read burst arlen=3 with i_rready toggling -> 4 beats of data 0, SLVERR, rlast only on beat 4, outputs stable under backpressure; write burst awlen=1 -> 2 beats consumed, single SLVERR, no register change.
REQ-040 Read of 0x800 -> DECERR, data 0; rst asserted during W_RESP -> bvalid drops the next cycle and all registers return to reset values.
